// File: rtl/csr_machine_file.sv
// Machine-mode CSR file: read mux, CSRRW/RS/RC updates, 64-bit counters,
// trap entry for exceptions / timer / external interrupts, and mret.
module csr_machine_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    input  logic        instr_retire,
    input  logic        exc_req,
    input  logic [31:0] exc_cause,
    input  logic        mret,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [31:0] MTVEC_INIT = MTVEC_RESET & ~32'h3;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0880;

    logic        st_mie_q, st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] mstatus_rd;
    logic [31:0] mip_rd;
    logic [31:0] wval;
    logic        irq_ext;
    logic        irq_tmr;
    logic        trap;
    logic        wr_en;

    assign mstatus_rd = 32'h0000_1800
                      | {24'd0, st_mpie_q, 7'd0}
                      | {28'd0, st_mie_q, 3'd0};
    assign mip_rd     = {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};

    assign irq_ext = st_mie_q & mie_q[11] & ext_irq;
    assign irq_tmr = st_mie_q & mie_q[7] & timer_irq;
    assign trap    = irq_ext | irq_tmr | exc_req;
    assign wr_en   = (csr_op != 2'b00) & ~trap & ~mret;

    assign redirect_valid = ~rst & (trap | mret);
    assign redirect_pc    = trap ? mtvec_q : mepc_q;

    // Combinational read of the addressed CSR (pre-update value)
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            12'h300: csr_rdata = mstatus_rd;
            12'h304: csr_rdata = mie_q;
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h344: csr_rdata = mip_rd;
            12'hB00: csr_rdata = mcycle_q[31:0];
            12'hB80: csr_rdata = mcycle_q[63:32];
            12'hB02: csr_rdata = minstret_q[31:0];
            12'hB82: csr_rdata = minstret_q[63:32];
            default: csr_rdata = 32'd0;
        endcase
    end

    // Read-modify-write value for the CSR instruction
    always_comb begin
        wval = csr_rdata;
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = csr_rdata | csr_wdata;
            2'b11:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
    end

    // Next state: trap > mret > CSR write, counters run underneath
    always_comb begin
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q;
        if (instr_retire && !trap) begin
            minstret_d = minstret_q + 64'd1;
        end
        if (trap) begin
            mepc_d    = pc & ~32'h3;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
            if (irq_ext) begin
                mcause_d = 32'h8000_000B;
            end else if (irq_tmr) begin
                mcause_d = 32'h8000_0007;
            end else begin
                mcause_d = exc_cause;
            end
        end else if (mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                12'h300: begin
                    st_mie_d  = wval[3];
                    st_mpie_d = wval[7];
                end
                12'h304: mie_d      = wval & MIE_MASK;
                12'h305: mtvec_d    = wval & ~32'h3;
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = wval & ~32'h3;
                12'h342: mcause_d   = wval;
                12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
                12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], wval};
                12'hB82: minstret_d = {wval, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_q      <= 32'd0;
            mtvec_q    <= MTVEC_INIT;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: doc/csr_machine_file.md
# csr_machine_file

Machine-mode control and status register file for the single-cycle RV32 core. It serves CSR read data to the writeback stage, where it is the `wb_sel = 2'b11` source. It applies CSRRW/CSRRS/CSRRC updates at the clock edge and keeps the 64-bit cycle and retired-instruction counters. It also handles trap entry (exceptions, timer and external interrupts) and `mret`, driving a PC redirect to the fetch stage.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] are forced to 0.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  32  PC of the instruction in the current cycle.
- csr_addr  in  12  CSR address from instr[31:20].
- csr_op  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- csr_wdata  in  32  rs1 value, or zero-extended zimm.
- instr_retire  in  1  the current instruction completes this cycle.
- exc_req  in  1  the current instruction raises a synchronous exception.
- exc_cause  in  32  exception code; bit 31 must be 0.
- mret  in  1  the current instruction is `mret`.
- timer_irq  in  1  level-sensitive machine timer interrupt.
- ext_irq  in  1  level-sensitive machine external interrupt.
- csr_rdata  out  32  combinational read of `csr_addr`, pre-update value.
- redirect_valid  out  1  fetch must load redirect_pc next.
- redirect_pc  out  32  trap vector or mepc.

## Operation
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] hardwired to 11; other bits read 0.
  - mie 0x304: MTIE bit7, MEIE bit11.
  - mtvec 0x305: direct mode only.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342.
  - mip 0x344: read-only; MTIP = timer_irq, MEIP = ext_irq.
  - mcycle/mcycleh 0xB00/0xB80.
  - minstret/minstreth 0xB02/0xB82.
- Unimplemented addresses read 0; writes to them are ignored. Writes to mip are ignored.
- New value for a CSR write:
  - RW: csr_wdata.
  - RS: old | csr_wdata.
  - RC: old & ~csr_wdata.
  - Write-masked per register as above.
- Interrupt pending: irq = mstatus.MIE & ((mie.MEIE & ext_irq) | (mie.MTIE & timer_irq)).
- Priority in a cycle: external interrupt > timer interrupt > exception > mret > CSR write.
- Trap (interrupt or exception) behaviour:
  - mepc <= pc.
  - mcause <= 0x8000_000B (external), 0x8000_0007 (timer), or exc_cause (exception).
  - MPIE <= MIE; MIE <= 0.
  - redirect_valid = 1; redirect_pc = mtvec.
  - The CSR write of that instruction is suppressed.
  - minstret does not increment.
- mret (no trap that cycle):
  - MIE <= MPIE; MPIE <= 1.
  - redirect_valid = 1; redirect_pc = mepc.
- mcycle behaviour:
  - The 64-bit counter increments every cycle.
  - A CSR write to either half wins over the increment in that cycle; the other half holds.
  - Wraps from 2^64-1 to 0.
- minstret behaviour:
  - Increments when instr_retire = 1 and no trap is taken.
  - Same write-precedence and wrap rules as mcycle.
  - A CSR write to minstret by a retiring instruction wins over the increment.

## Timing
- csr_rdata, redirect_valid and redirect_pc are combinational in the same cycle; state updates on the following edge.
- A read in the cycle after a write returns the new value (zero-cycle latency to the next instruction).
- Reset values while rst = 1, effective immediately (asynchronous):
  - mstatus = 0x0000_1800.
  - mie = mepc = mcause = mscratch = 0.
  - mtvec = MTVEC_RESET & ~3.
  - Counters = 0.
  - redirect_valid = 0.
- Deasserting rst mid-operation: the first edge after release performs a normal update (mcycle becomes 1).
- Interrupt inputs are levels; a pending interrupt re-traps every cycle until MIE, the enable bit, or the source clears.

## Test plan
- Reset: assert rst mid-run -> mstatus reads 0x1800, mtvec reads 0, mcycle reads 0; first cycle after release mcycle reads 1.
- CSR ops:
  - RW mscratch 0xDEAD_BEEF -> reads back 0xDEAD_BEEF.
  - RS 0x0000_00F0 then RC 0x0000_0030 -> reads 0xDEAD_BECF.
  - RW mepc 0x1003 -> reads 0x1000.
- Timer trap:
  - Setup: mtvec = 0x200, mie = 0x80, mstatus = 0x8, timer_irq = 1, pc = 0x44.
  - Expected: redirect_pc = 0x200, then mepc = 0x44, mcause = 0x8000_0007, mstatus = 0x1880.
  - Then: mret -> redirect_pc = 0x44, mstatus = 0x1888.
- Simultaneous events:
  - ext_irq and timer_irq together -> mcause = 0x8000_000B.
  - exc_req (cause 2) with a CSR RW to mscratch in the same cycle -> mscratch unchanged, mcause = 2, minstret unchanged.
- Counter wrap: RW mcycle = 0xFFFF_FFFF and mcycleh = 0xFFFF_FFFF -> next cycle both halves read 0; write in a cycle overrides the increment.
- Unimplemented and read-only: RW 0x7C0 = 5 -> reads 0; RW to mip -> mip still mirrors the irq inputs.
